// File: rtl/sum_stationary_pkg.sv
// Shared definitions for the sum_stationary array and its downstream stages.
//   c_width()      : width of one accumulated result element.
//   bank_state_t   : occupancy state of one tile bank.
//   drain_dbg_t    : packed snapshot of the drain control state (debug port).
package sum_stationary_pkg;

    function automatic int c_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    // Bit layout, MSB first: bank0, bank1, wr_bank, rd_bank, count[1:0].
    typedef struct packed {
        bank_state_t bank0;
        bank_state_t bank1;
        logic        wr_bank;
        logic        rd_bank;
        logic [1:0]  count;
    } drain_dbg_t;

endpackage

// File: rtl/sum_stationary_tile_bank.sv
// One N x N result tile register bank.
//   i_clk  : clock
//   i_we   : capture strobe; copies the whole tile i_d on this edge
//   i_d    : N*N elements, element r*N+c is row r, column c
//   i_sel  : row select for the read port
//   o_row  : N elements of the selected row (combinational read)
module sum_stationary_tile_bank
    import sum_stationary_pkg::*;
#(
    parameter int W  = 18,
    parameter int N  = 4,
    parameter int RW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [W-1:0]  i_d [N*N],
    input  logic [RW-1:0] i_sel,
    output logic [W-1:0]  o_row [N]
);

    // Contents are not reset: a bank is only read while it is marked full.
    logic [W-1:0] r_mem [N][N];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_mem[r][c] <= i_d[r*N + c];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) begin
            o_row[c] = r_mem[i_sel][c];
        end
    end

endmodule

// File: rtl/sum_stationary_drain.sv
// Ping-pong drain stage behind the sum_stationary array. Captures a full
// N x N result tile when valid_i pulses and streams it out one row per beat.
//   clk_i, reset_i : clock, synchronous active-high reset
//   valid_i, c_i   : tile strobe and tile from the array (no backpressure)
//   ready_i        : downstream accepts the presented row
//   valid_o, row_o : presented row and its qualifier
//   row_idx_o      : row number within the tile, last_o marks row N-1
//   overflow_o     : sticky, a tile arrived with both banks full and was lost
//   busy_o         : at least one bank holds an undrained tile
//   dbg_state_o    : drain_dbg_t snapshot of bank states, pointers and count
//
// Handshake: a row transfers on every clk_i edge where valid_o && ready_i.
// Once valid_o is high, row_o/row_idx_o/last_o stay stable until that
// transfer; valid_o only falls after a transfer or on reset.
module sum_stationary_drain
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = c_width(DATA_WIDTH, N)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [C_DATA_WIDTH-1:0] c_i [N*N],
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [C_DATA_WIDTH-1:0] row_o [N],
    output logic [$clog2(N)-1:0]    row_idx_o,
    output logic                    last_o,
    output logic                    overflow_o,
    output logic                    busy_o,
    output logic [5:0]              dbg_state_o
);

    localparam int             RW       = $clog2(N);
    localparam logic [RW-1:0]  LAST_ROW = RW'(N - 1);

    bank_state_t   r_bank0;
    bank_state_t   r_bank1;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [RW-1:0] r_row;
    logic          r_overflow;

    logic [1:0]    w_count;
    logic          w_valid;
    logic          w_beat;
    logic          w_final;
    logic          w_cap;
    logic          w_drop;
    logic [C_DATA_WIDTH-1:0] w_q0 [N];
    logic [C_DATA_WIDTH-1:0] w_q1 [N];
    drain_dbg_t    w_dbg;

    assign w_count = {1'b0, r_bank0 == BANK_FULL} + {1'b0, r_bank1 == BANK_FULL};
    assign w_valid = (w_count != 2'd0);
    assign w_beat  = w_valid && ready_i;
    assign w_final = w_beat && (r_row == LAST_ROW);
    // With both banks full, wr_bank == rd_bank, so a final-row beat frees
    // exactly the bank the incoming tile is about to be written into.
    assign w_cap   = valid_i && ((w_count != 2'd2) || w_final);
    assign w_drop  = valid_i && !w_cap;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bank0    <= BANK_EMPTY;
            r_bank1    <= BANK_EMPTY;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_row      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_beat) begin
                if (w_final) begin
                    r_row     <= '0;
                    r_rd_bank <= ~r_rd_bank;
                    if (r_rd_bank) r_bank1 <= BANK_EMPTY;
                    else           r_bank0 <= BANK_EMPTY;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end
            // Placed after the release so a same-bank capture wins.
            if (w_cap) begin
                r_wr_bank <= ~r_wr_bank;
                if (r_wr_bank) r_bank1 <= BANK_FULL;
                else           r_bank0 <= BANK_FULL;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sum_stationary_tile_bank #(.W(C_DATA_WIDTH), .N(N), .RW(RW)) u_bank0 (
        .i_clk (clk_i),
        .i_we  (w_cap && !r_wr_bank),
        .i_d   (c_i),
        .i_sel (r_row),
        .o_row (w_q0)
    );

    sum_stationary_tile_bank #(.W(C_DATA_WIDTH), .N(N), .RW(RW)) u_bank1 (
        .i_clk (clk_i),
        .i_we  (w_cap && r_wr_bank),
        .i_d   (c_i),
        .i_sel (r_row),
        .o_row (w_q1)
    );

    always_comb begin
        for (int c = 0; c < N; c++) begin
            row_o[c] = r_rd_bank ? w_q1[c] : w_q0[c];
        end
    end

    assign valid_o    = w_valid;
    assign row_idx_o  = r_row;
    assign last_o     = w_valid && (r_row == LAST_ROW);
    assign overflow_o = r_overflow;
    assign busy_o     = w_valid;

    assign w_dbg.bank0   = r_bank0;
    assign w_dbg.bank1   = r_bank1;
    assign w_dbg.wr_bank = r_wr_bank;
    assign w_dbg.rd_bank = r_rd_bank;
    assign w_dbg.count   = w_count;
    assign dbg_state_o   = w_dbg;

endmodule

// File: tb/tb_sum_stationary_drain.sv
// Directed bench for sum_stationary_drain: a per-cycle vector table for the
// single-tile, backpressure and ping-pong cases, plus hand-written sequences
// (overflow, capture on final beat at count=2, reset mid-drain) checked
// through an expected-row queue.
module tb_sum_stationary_drain;
    import sum_stationary_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = c_width(DW, N);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          valid_i;
    logic [CW-1:0] c_i [N*N];
    logic          ready_i;
    logic          valid_o;
    logic [CW-1:0] row_o [N];
    logic [1:0]    row_idx_o;
    logic          last_o;
    logic          overflow_o;
    logic          busy_o;
    logic [5:0]    dbg_state_o;

    int n_checks = 0;
    int n_err    = 0;

    logic [CW-1:0] exp_q [$];
    int            idx_q [$];

    typedef struct {
        logic vin;
        int   base_in;
        logic rdy;
        logic e_vld;
        int   e_base;
        int   e_idx;
        logic e_last;
        logic e_busy;
        logic e_ovf;
    } vec_t;

    vec_t vecs [$];

    sum_stationary_drain #(.DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .c_i         (c_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .row_o       (row_o),
        .row_idx_o   (row_idx_o),
        .last_o      (last_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int ctx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0d expected %0d", nm, ctx, act, exp);
        end
    endtask

    task automatic add(input logic vin, input int base_in, input logic rdy,
                       input logic e_vld, input int e_base, input int e_idx,
                       input logic e_last, input logic e_busy, input logic e_ovf);
        vec_t v;
        v.vin = vin; v.base_in = base_in; v.rdy = rdy;
        v.e_vld = e_vld; v.e_base = e_base; v.e_idx = e_idx;
        v.e_last = e_last; v.e_busy = e_busy; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic push_tile(input int base);
        for (int r = 0; r < N; r++) begin
            exp_q.push_back(CW'(base + N*r));
            idx_q.push_back(r);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then look at the
    // outputs 1ns later (well before the next rising edge). With use_sb set,
    // every beat is matched against the head of the expected-row queue.
    task automatic drive(input logic rst, input logic vin, input int base,
                         input logic rdy, input logic use_sb);
        logic [CW-1:0] v;
        int            r;
        @(negedge clk_i);
        reset_i = rst;
        valid_i = vin;
        ready_i = rdy;
        for (int k = 0; k < N*N; k++) c_i[k] = CW'(base + k);
        #1;
        if (use_sb && rdy && !rst && valid_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: unexpected beat row_idx=%0d row0=%0d", row_idx_o, row_o[0]);
            end else begin
                v = exp_q.pop_front();
                r = idx_q.pop_front();
                chk("sb_idx", int'(v), 32'(row_idx_o), r);
                chk("sb_last", int'(v), 32'(last_o), (r == N-1) ? 1 : 0);
                for (int c = 0; c < N; c++) chk("sb_row", int'(v), 32'(row_o[c]), 32'(v) + c);
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < max_cycles) begin
            drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
            cyc++;
        end
        chk("drain_done", cyc, exp_q.size(), 0);
        exp_q.delete();
        idx_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        for (int k = 0; k < N*N; k++) c_i[k] = '0;

        // Single tile, ready tied high: capture at T, rows T+1..T+4.
        add(1, 1, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1,   1, 1, 0, 0, 1, 0);
        add(0, 0, 1,   1, 1, 1, 0, 1, 0);
        add(0, 0, 1,   1, 1, 2, 0, 1, 0);
        add(0, 0, 1,   1, 1, 3, 1, 1, 0);
        add(0, 0, 1,   0, 0, 0, 0, 0, 0);
        // Backpressure: ready 1,0,0,1,1,0,1 after capture.
        add(1, 1, 0,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1,   1, 1, 0, 0, 1, 0);
        add(0, 0, 0,   1, 1, 1, 0, 1, 0);
        add(0, 0, 0,   1, 1, 1, 0, 1, 0);
        add(0, 0, 1,   1, 1, 1, 0, 1, 0);
        add(0, 0, 1,   1, 1, 2, 0, 1, 0);
        add(0, 0, 0,   1, 1, 3, 1, 1, 0);
        add(0, 0, 1,   1, 1, 3, 1, 1, 0);
        add(0, 0, 1,   0, 0, 0, 0, 0, 0);
        // Ping-pong: A (base 0), B (base 100) two cycles later.
        add(1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1,   1, 0, 0, 0, 1, 0);
        add(1, 100, 1, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1,   1, 0, 2, 0, 1, 0);
        add(0, 0, 1,   1, 0, 3, 1, 1, 0);
        add(0, 0, 1,   1, 100, 0, 0, 1, 0);
        add(0, 0, 1,   1, 100, 1, 0, 1, 0);
        add(0, 0, 1,   1, 100, 2, 0, 1, 0);
        add(0, 0, 1,   1, 100, 3, 1, 1, 0);
        add(0, 0, 1,   0, 0, 0, 0, 0, 0);
        // Capture on the final beat with count=1: B follows A at row 0.
        add(1, 1, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1,   1, 1, 0, 0, 1, 0);
        add(0, 0, 1,   1, 1, 1, 0, 1, 0);
        add(0, 0, 1,   1, 1, 2, 0, 1, 0);
        add(1, 100, 1, 1, 1, 3, 1, 1, 0);
        add(0, 0, 1,   1, 100, 0, 0, 1, 0);
        add(0, 0, 1,   1, 100, 1, 0, 1, 0);
        add(0, 0, 1,   1, 100, 2, 0, 1, 0);
        add(0, 0, 1,   1, 100, 3, 1, 1, 0);
        add(0, 0, 1,   0, 0, 0, 0, 0, 0);

        // Reset, with valid_i high to show reset takes priority.
        drive(1'b1, 1'b1, 5, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 5, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("rst_valid", 0, 32'(valid_o), 0);
        chk("rst_busy", 0, 32'(busy_o), 0);
        chk("rst_ovf", 0, 32'(overflow_o), 0);
        chk("rst_idx", 0, 32'(row_idx_o), 0);
        chk("rst_last", 0, 32'(last_o), 0);
        chk("rst_dbg", 0, 32'(dbg_state_o), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b0, vecs[i].vin, vecs[i].base_in, vecs[i].rdy, 1'b0);
            chk("vec_valid", i, 32'(valid_o), 32'(vecs[i].e_vld));
            chk("vec_idx", i, 32'(row_idx_o), vecs[i].e_idx);
            chk("vec_last", i, 32'(last_o), 32'(vecs[i].e_last));
            chk("vec_busy", i, 32'(busy_o), 32'(vecs[i].e_busy));
            chk("vec_ovf", i, 32'(overflow_o), 32'(vecs[i].e_ovf));
            if (vecs[i].e_vld) begin
                for (int c = 0; c < N; c++)
                    chk("vec_row", i*10 + c, 32'(row_o[c]), vecs[i].e_base + N*vecs[i].e_idx + c);
            end
        end

        // Overflow: A, B, C with ready low; C is dropped.
        drive(1'b0, 1'b1, 0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 100, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 200, 1'b0, 1'b1);
        chk("ovf_before", 0, 32'(overflow_o), 0);
        chk("ovf_dbg_full", 0, 32'(dbg_state_o), 32'b110010);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("ovf_after", 0, 32'(overflow_o), 1);
        chk("ovf_hold_idx", 0, 32'(row_idx_o), 0);
        chk("ovf_hold_row", 0, 32'(row_o[0]), 0);
        push_tile(0);
        push_tile(100);
        drain(20);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("ovf_idle_valid", 0, 32'(valid_o), 0);
        chk("ovf_sticky", 0, 32'(overflow_o), 1);

        // Reset mid-drain (overflow is still set going in).
        exp_q.push_back(CW'(1));
        idx_q.push_back(0);
        drive(1'b0, 1'b1, 1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("mid_idx1", 0, 32'(row_idx_o), 1);
        chk("mid_valid", 0, 32'(valid_o), 1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("mid_rst_valid", 0, 32'(valid_o), 0);
        chk("mid_rst_busy", 0, 32'(busy_o), 0);
        chk("mid_rst_ovf", 0, 32'(overflow_o), 0);
        chk("mid_rst_idx", 0, 32'(row_idx_o), 0);
        chk("mid_rst_dbg", 0, 32'(dbg_state_o), 0);
        chk("mid_sb_empty", 0, exp_q.size(), 0);
        drive(1'b0, 1'b1, 100, 1'b1, 1'b1);
        push_tile(100);
        drain(10);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // Capture C on the cycle A's row 3 beats while B is also held.
        push_tile(0);
        push_tile(100);
        push_tile(200);
        drive(1'b0, 1'b1, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 100, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("sim_count2", 0, 32'(dbg_state_o[1:0]), 2);
        drive(1'b0, 1'b1, 200, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("sim_count_stays2", 0, 32'(dbg_state_o[1:0]), 2);
        chk("sim_ovf", 0, 32'(overflow_o), 0);
        drain(20);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("sim_ovf_end", 0, 32'(overflow_o), 0);
        chk("sim_busy_end", 0, 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
